// File: rtl/main_memory_arbiter.sv
// main_memory_arbiter
//   Round-robin arbiter that shares one single-port main memory among
//   NUM_PORTS requesters. A grant is held for the owner's whole transaction
//   (every consecutive nonzero req_msg cycle, so bursts stay atomic). A
//   one-cycle RELEASE state puts a NO_REQ cycle on the memory bus between
//   owners. Memory responses are routed back to the most recent owner in
//   every state, so responses that arrive late still reach that owner.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   req_msg/address/data  : per-port requests, port i at slice [i*W +: W]
//   resp_msg/address/data : per-port routed memory responses (0 if not owner)
//   mem_*_out             : request forwarded to memory (0 unless granted)
//   mem_*_in              : response coming back from memory
//   grant                 : one-hot grant, all zero outside GRANT
module main_memory_arbiter #(
    parameter int NUM_PORTS     = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MSG_BITS      = 4
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_PORTS*MSG_BITS-1:0]      req_msg,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_PORTS*MSG_BITS-1:0]      resp_msg,
    output logic [NUM_PORTS*ADDRESS_WIDTH-1:0] resp_address,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    resp_data,
    output logic [MSG_BITS-1:0]                mem_msg_out,
    output logic [ADDRESS_WIDTH-1:0]           mem_address_out,
    output logic [DATA_WIDTH-1:0]              mem_data_out,
    input  logic [MSG_BITS-1:0]                mem_msg_in,
    input  logic [ADDRESS_WIDTH-1:0]           mem_address_in,
    input  logic [DATA_WIDTH-1:0]              mem_data_in,
    output logic [NUM_PORTS-1:0]               grant
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cur_q, cur_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic             owner_valid_q, owner_valid_d;

    // Unpacked views of the flat request buses.
    logic [MSG_BITS-1:0]      req_msg_arr  [NUM_PORTS];
    logic [ADDRESS_WIDTH-1:0] req_addr_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]    req_data_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]     requesting;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign req_msg_arr[gi]  = req_msg[gi*MSG_BITS +: MSG_BITS];
            assign req_addr_arr[gi] = req_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign requesting[gi]   = |req_msg_arr[gi];
        end
    endgenerate

    // Round-robin pick: first requester scanning last+1, last+2, ... with an
    // explicit wrap so non-power-of-two port counts never index past the end.
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = last_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            if (!sel_found && requesting[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        last_d        = last_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d       = ST_GRANT;
                    cur_d         = sel_idx;
                    last_d        = sel_idx;
                    owner_d       = sel_idx;
                    owner_valid_d = 1'b1;
                end
            end
            ST_GRANT: begin
                // Owner ends its transaction by presenting NO_REQ.
                if (!requesting[cur_q]) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            last_q        <= LAST_IDX;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            last_q        <= last_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
        end
    end

    // Outputs are forced to zero while reset is held so nothing leaks out
    // before the registers have been cleared.
    logic fwd_active;
    assign fwd_active = (state_q == ST_GRANT) && !reset;

    assign mem_msg_out     = fwd_active ? req_msg_arr[cur_q]  : '0;
    assign mem_address_out = fwd_active ? req_addr_arr[cur_q] : '0;
    assign mem_data_out    = fwd_active ? req_data_arr[cur_q] : '0;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_route
            logic route;
            assign route     = owner_valid_q && !reset && (owner_q == IDX_W'(gi));
            assign grant[gi] = fwd_active && (cur_q == IDX_W'(gi));
            assign resp_msg[gi*MSG_BITS +: MSG_BITS] =
                route ? mem_msg_in : '0;
            assign resp_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH] =
                route ? mem_address_in : '0;
            assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                route ? mem_data_in : '0;
        end
    endgenerate

endmodule

// File: tb/tb_main_memory_arbiter.sv
// Directed scoreboard bench for main_memory_arbiter (2 ports, 32-bit).
// The stimulus task drives one cycle of inputs and pushes the hand-stated
// expected grant/owner for that cycle; a negedge monitor pops and compares.
module tb_main_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  req_msg = '0;
    logic [63:0] req_address = '0;
    logic [63:0] req_data = '0;
    logic [7:0]  resp_msg;
    logic [63:0] resp_address;
    logic [63:0] resp_data;
    logic [3:0]  mem_msg_out;
    logic [31:0] mem_address_out;
    logic [31:0] mem_data_out;
    logic [3:0]  mem_msg_in = '0;
    logic [31:0] mem_address_in = '0;
    logic [31:0] mem_data_in = '0;
    logic [1:0]  grant;

    main_memory_arbiter #(
        .NUM_PORTS(2), .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .MSG_BITS(4)
    ) dut (
        .clock(clock), .reset(reset),
        .req_msg(req_msg), .req_address(req_address), .req_data(req_data),
        .resp_msg(resp_msg), .resp_address(resp_address), .resp_data(resp_data),
        .mem_msg_out(mem_msg_out), .mem_address_out(mem_address_out),
        .mem_data_out(mem_data_out),
        .mem_msg_in(mem_msg_in), .mem_address_in(mem_address_in),
        .mem_data_in(mem_data_in),
        .grant(grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  g;
        logic [3:0]  mmsg;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic [7:0]  rmsg;
        logic [63:0] raddr;
        logic [63:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // One cycle of stimulus. Write data is derived from the address so every
    // port/word carries distinct data. own = expected response owner (-1 none).
    task automatic step(input string name, input logic rst,
                        input logic [3:0] m0, input logic [31:0] a0,
                        input logic [3:0] m1, input logic [31:0] a1,
                        input logic [3:0] mi, input logic [31:0] ai,
                        input logic [1:0] g, input int own);
        exp_t e;
        logic [31:0] d0, d1, di;
        d0 = a0 ^ 32'hA5A5_0000;
        d1 = a1 ^ 32'h5A5A_0000;
        di = ai ^ 32'h0F0F_0000;
        @(posedge clock);
        #1;
        reset          = rst;
        req_msg        = {m1, m0};
        req_address    = {a1, a0};
        req_data       = {d1, d0};
        mem_msg_in     = mi;
        mem_address_in = ai;
        mem_data_in    = di;
        e.name  = name;
        e.g     = g;
        e.mmsg  = g[0] ? m0 : (g[1] ? m1 : 4'h0);
        e.maddr = g[0] ? a0 : (g[1] ? a1 : 32'h0);
        e.mdata = g[0] ? d0 : (g[1] ? d1 : 32'h0);
        e.rmsg  = '0;
        e.raddr = '0;
        e.rdata = '0;
        if (own == 0) begin
            e.rmsg[3:0]   = mi;
            e.raddr[31:0] = ai;
            e.rdata[31:0] = di;
        end else if (own == 1) begin
            e.rmsg[7:4]    = mi;
            e.raddr[63:32] = ai;
            e.rdata[63:32] = di;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (grant !== mon_e.g || mem_msg_out !== mon_e.mmsg ||
                mem_address_out !== mon_e.maddr || mem_data_out !== mon_e.mdata ||
                resp_msg !== mon_e.rmsg || resp_address !== mon_e.raddr ||
                resp_data !== mon_e.rdata) begin
                errors++;
                $display("FAIL %s: got grant=%b mem=%h/%h/%h resp=%h/%h/%h, want grant=%b mem=%h/%h/%h resp=%h/%h/%h",
                         mon_e.name, grant, mem_msg_out, mem_address_out, mem_data_out,
                         resp_msg, resp_address, resp_data,
                         mon_e.g, mon_e.mmsg, mon_e.maddr, mon_e.mdata,
                         mon_e.rmsg, mon_e.raddr, mon_e.rdata);
            end else begin
                $display("ok   %s: grant=%b mem_msg=%h mem_addr=%h resp_msg=%h",
                         mon_e.name, grant, mem_msg_out, mem_address_out, resp_msg);
            end
        end
    end

    initial begin
        int prev;
        int p;
        logic [1:0] gp;
        // Reset: outputs stay zero even with requests and memory traffic.
        step("rst0", 1, 1, 'h40, 1, 'h80, 3, 'h44, 2'b00, -1);
        step("rst1", 1, 1, 'h40, 0, 0,    3, 'h44, 2'b00, -1);
        // Single port: request in IDLE, grant next cycle, reply routed.
        step("s_idle",  0, 1, 'h40, 0, 0, 0, 0,     2'b00, -1);
        step("s_grant", 0, 1, 'h40, 0, 0, 0, 0,     2'b01, 0);
        step("s_hold",  0, 1, 'h40, 0, 0, 3, 'h40,  2'b01, 0);
        step("s_drop",  0, 0, 'h40, 0, 0, 3, 'h40,  2'b01, 0);
        // Late responses in RELEASE and IDLE still go to port 0.
        step("s_rel",   0, 0, 0,    0, 0, 3, 'h44,  2'b00, 0);
        step("s_idle2", 0, 0, 0,    0, 0, 5, 'h48,  2'b00, 0);
        // Simultaneous requests: last=0, so port 1 wins, then port 0.
        step("b_idle",  0, 1, 'h10, 1, 'h20,  0, 0,     2'b00, 0);
        step("b_g1",    0, 1, 'h10, 1, 'h20,  0, 0,     2'b10, 1);
        step("b_d1",    0, 1, 'h10, 0, 'h20,  2, 'h20,  2'b10, 1);
        step("b_rel1",  0, 1, 'h10, 0, 0,     2, 'h24,  2'b00, 1);
        step("b_idle0", 0, 1, 'h10, 0, 0,     0, 0,     2'b00, 1);
        step("b_g0",    0, 1, 'h10, 1, 'h100, 0, 0,     2'b01, 0);
        step("b_d0",    0, 0, 'h10, 1, 'h100, 3, 'h10,  2'b01, 0);
        step("b_rel0",  0, 0, 0,    1, 'h100, 0, 0,     2'b00, 0);
        step("b_idle1", 0, 0, 0,    1, 'h100, 0, 0,     2'b00, 0);
        // Burst on port 1 while port 0 waits.
        step("burst0",     0, 2, 'h200, 1, 'h100, 0, 0,      2'b10, 1);
        step("burst1",     0, 2, 'h200, 1, 'h104, 0, 0,      2'b10, 1);
        step("burst2",     0, 2, 'h200, 1, 'h108, 4, 'h100,  2'b10, 1);
        step("burst3",     0, 2, 'h200, 1, 'h10C, 4, 'h104,  2'b10, 1);
        step("burst_end",  0, 2, 'h200, 0, 0,     0, 0,      2'b10, 1);
        step("burst_rel",  0, 2, 'h200, 0, 0,     0, 0,      2'b00, 1);
        step("burst_idle", 0, 2, 'h200, 0, 0,     0, 0,      2'b00, 1);
        step("burst_p0",   0, 2, 'h200, 0, 0,     0, 0,      2'b01, 0);
        // Reset mid-GRANT: everything zero, then port 0 wins first again.
        step("mid_hold",   0, 2, 'h204, 1, 'h300, 0, 0,      2'b01, 0);
        step("mid_rst",    1, 2, 'h204, 1, 'h300, 6, 'h60,   2'b00, -1);
        step("post_idle",  0, 1, 'h208, 1, 'h300, 6, 'h60,   2'b00, -1);
        step("post_g0",    0, 1, 'h208, 1, 'h300, 0, 0,      2'b01, 0);
        step("post_d0",    0, 0, 0,     1, 'h300, 0, 0,      2'b01, 0);
        step("post_rel",   0, 0, 0,     1, 'h300, 0, 0,      2'b00, 0);
        step("post_idle1", 0, 0, 0,     1, 'h300, 0, 0,      2'b00, 0);
        step("post_g1",    0, 0, 0,     1, 'h300, 0, 0,      2'b10, 1);
        step("post_d1",    0, 0, 0,     0, 0,     0, 0,      2'b10, 1);
        step("post_rel1",  0, 0, 0,     0, 0,     0, 0,      2'b00, 1);
        step("post_idle2", 0, 0, 0,     0, 0,     0, 0,      2'b00, 1);
        // Fairness: both ports request continuously; grants must alternate.
        prev = 1;
        for (int t = 0; t < 8; t++) begin
            p  = t % 2;
            gp = (p == 0) ? 2'b01 : 2'b10;
            step($sformatf("rr%0d_idle", t), 0, 1, 'h500 + t, 1, 'h600 + t,
                 0, 0, 2'b00, prev);
            step($sformatf("rr%0d_grant", t), 0, 1, 'h500 + t, 1, 'h600 + t,
                 7, 'h700 + t, gp, p);
            step($sformatf("rr%0d_drop", t), 0,
                 (p == 0) ? 4'h0 : 4'h1, 'h500 + t,
                 (p == 1) ? 4'h0 : 4'h1, 'h600 + t,
                 7, 'h710 + t, gp, p);
            step($sformatf("rr%0d_rel", t), 0, 1, 'h500 + t, 1, 'h600 + t,
                 8, 'h720 + t, 2'b00, p);
            prev = p;
        end
        step("end_idle0", 0, 0, 0, 0, 0, 0, 0, 2'b00, prev);
        step("end_idle1", 0, 0, 0, 0, 0, 9, 'h90, 2'b00, prev);
        // Bounded drain of the scoreboard.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Round-robin arbiter that shares a single-port `main_memory` among `NUM_PORTS` requesters, each speaking the main-memory message protocol (msg/address/data). Typical requesters are per-core `main_memory_interface` instances. It sits between those interfaces and `main_memory` in multi-core tops. It grants one requester at a time and holds the grant for that requester's whole transaction, including multi-word bursts. It forwards the granted requester's messages to memory and routes every memory response back to the current owner.

## Interface
- `NUM_PORTS`, 2: number of requesters; must be ≥2.
- `DATA_WIDTH`, 32: word width.
- `ADDRESS_WIDTH`, 32: address width.
- `MSG_BITS`, 4: message width; value 0 means NO_REQ (idle).

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_msg` in NUM_PORTS*MSG_BITS: per-port request message; port i occupies slice [i*MSG_BITS +: MSG_BITS].
- `req_address` in NUM_PORTS*ADDRESS_WIDTH: per-port request address.
- `req_data` in NUM_PORTS*DATA_WIDTH: per-port write data.
- `resp_msg` out NUM_PORTS*MSG_BITS: per-port routed memory message.
- `resp_address` out NUM_PORTS*ADDRESS_WIDTH: per-port routed address.
- `resp_data` out NUM_PORTS*DATA_WIDTH: per-port routed data.
- `mem_msg_out` out MSG_BITS: message to memory.
- `mem_address_out` out ADDRESS_WIDTH: address to memory.
- `mem_data_out` out DATA_WIDTH: data to memory.
- `mem_msg_in` in MSG_BITS: message from memory.
- `mem_address_in` in ADDRESS_WIDTH: address from memory.
- `mem_data_in` in DATA_WIDTH: data from memory.
- `grant` out NUM_PORTS: one-hot current grant; all zero when not in GRANT.

## Operation
- States: IDLE, GRANT, RELEASE. Registers:
  - `state`
  - `cur` (granted index)
  - `last` (most recent grant index for round-robin)
  - `owner` (response-routing index)
  - `owner_valid`
- A port is requesting when its req_msg != 0.
- IDLE:
  - If any port is requesting, select the first requesting port scanning (last+1), (last+2), … modulo NUM_PORTS.
  - Next state: GRANT; cur, last and owner take the selected index; owner_valid is set.
  - If no port is requesting, stay in IDLE.
- GRANT:
  - mem_*_out equal req_*[cur] combinationally.
  - grant[cur] = 1.
  - If req_msg[cur] == 0 in this cycle, next state is RELEASE. Memory sees NO_REQ that cycle because the signal is forwarded.
  - Otherwise stay in GRANT; there is no hold limit.
- RELEASE: lasts one cycle with grant = 0 and mem_*_out = 0, then goes to IDLE. This guarantees one NO_REQ cycle between owners.
- Response routing:
  - When owner_valid is set, resp_*[owner] = mem_*_in combinationally in every state. This covers memory responses that lag into RELEASE or IDLE.
  - All other ports' resp_* = 0.
  - owner changes only when a new grant is made.
- Outputs outside GRANT: mem_msg_out, mem_address_out and mem_data_out are 0 in IDLE and RELEASE.
- Reset:
  - state = IDLE, cur = 0, last = NUM_PORTS-1 (so port 0 wins first), owner = 0, owner_valid = 0.
  - All outputs are 0 during and after reset until the first grant.
  - Reset mid-GRANT aborts forwarding in the same edge; the requester must retry.
- Index arithmetic uses $clog2(NUM_PORTS) bits with explicit wrap from NUM_PORTS-1 to 0, so non-power-of-two NUM_PORTS works.

## Timing
- Grant latency: request asserted in IDLE at cycle t gives grant and forwarding at t+1. Minimum turnaround between owners is 2 cycles (drop to 0 at t gives RELEASE at t+1 and IDLE at t+2). A new grant is visible at t+3.
- Forwarding and response paths add zero cycles (combinational mux); memory latency is unchanged.
- Simultaneous requests in IDLE: round-robin order from last+1. A port that drops its request before being granted is skipped.
- A port's request rising while another port is in GRANT or RELEASE waits; it is never dropped, only delayed.
- Bursts: multi-word transactions (consecutive nonzero req_msg cycles) stay atomic under one grant.

## Test plan
- **Single port:** after reset, port0 msg=R_REQ(1), addr=0x40 from cycle 2 → grant=01 at cycle 3, mem_address_out=0x40. Memory reply msg=3 at cycle 5 → resp_msg[0]=3, resp_msg[1]=0.
- **Simultaneous requests:** both ports request at cycle 2 → port0 granted at cycle 3. Port0 drops at cycle 6 → RELEASE at cycle 7 with mem_msg_out=0. Port1 granted at cycle 9.
- **Round-robin fairness:** both ports request continuously, dropping 1 cycle after each response → grants alternate 0,1,0,1 across 8 transactions; neither port is granted twice in a row.
- **Late response:** memory responds in the RELEASE cycle and the following IDLE cycle → the response is routed to the previous owner; the other port's resp_* stays 0.
- **Burst atomicity:** port1 holds nonzero msg for 4 cycles (addresses 0x100–0x10C) while port0 requests → mem_address_out sequence is 0x100, 0x104, 0x108, 0x10C uninterrupted; port0 is granted only afterward.
- **Reset mid-GRANT:** assert reset at cycle 5 while port0 is granted → grant=0, mem_msg_out=0, all resp_*=0 at cycle 6. After release, port0 again wins first.
